// File: rtl/calc_prio_pkg.sv
// Shared types and helpers for the calc priority arbiter: NOP encoding, lane classes,
// and the opcode-class function that steers a command to its ALU lane.
package calc_prio_pkg;

  localparam int CMD_NOP = 0;

  typedef enum logic [1:0] {
    LANE_NONE  = 2'd0,
    LANE_ADD   = 2'd1,
    LANE_SHIFT = 2'd2
  } lane_e;

  // Class depends only on the command, so a slot is never eligible for both lanes.
  function automatic lane_e cmd_lane(input logic [31:0] cmd, input logic [31:0] min_shift);
    lane_e lane;
    if (cmd == 32'(CMD_NOP)) begin
      lane = LANE_NONE;
    end else if (cmd >= min_shift) begin
      lane = LANE_SHIFT;
    end else begin
      lane = LANE_ADD;
    end
    return lane;
  endfunction

endpackage

// File: rtl/calc_prio_sel.sv
// Grant selector for one ALU lane: first eligible port found searching upward from ptr
// (wrapping). With ptr tied to zero this is fixed priority, port 0 highest.
module calc_prio_sel #(
  parameter int NUM_PORTS = 4,
  parameter int PID_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] elig,
  input  logic [PID_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PID_W-1:0]     idx,
  output logic                 any
);

  // Rotating first-one search starting at ptr.
  always_comb begin
    logic [PID_W:0]   sum;
    logic [PID_W-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    j     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sum = {1'b0, ptr} + (PID_W+1)'(i);
      if (sum >= (PID_W+1)'(NUM_PORTS)) begin
        sum = sum - (PID_W+1)'(NUM_PORTS);
      end else begin
        sum = sum;
      end
      j = sum[PID_W-1:0];
      if (!any && elig[j]) begin
        any      = 1'b1;
        idx      = j;
        grant[j] = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/calc_prio_arb.sv
// Two-lane priority arbiter: one pending slot per port, add/sub commands to lane 1 and
// shift commands to lane 2. Define PRIO_RR_EN for per-lane round-robin, else fixed priority.
module calc_prio_arb
  import calc_prio_pkg::*;
#(
  parameter  int NUM_PORTS    = 4,
  parameter  int CMD_W        = 4,
  parameter  int TAG_W        = 2,
  parameter  int ALU2_MIN_CMD = 4,
  localparam int PID_W        = $clog2(NUM_PORTS)
) (
  input  logic                       c_clk,
  input  logic                       reset,
  input  logic [NUM_PORTS-1:0]       req_vld,
  input  logic [NUM_PORTS*CMD_W-1:0] req_cmd,
  input  logic [NUM_PORTS*TAG_W-1:0] req_tag,
  output logic [NUM_PORTS-1:0]       req_rdy,
  input  logic [NUM_PORTS-1:0]       port_en,
  output logic                       alu1_out_vld,
  input  logic                       alu1_out_rdy,
  output logic [CMD_W-1:0]           alu1_out_cmd,
  output logic [PID_W-1:0]           alu1_out_pid,
  output logic [TAG_W-1:0]           alu1_out_tag,
  output logic                       alu2_out_vld,
  input  logic                       alu2_out_rdy,
  output logic [CMD_W-1:0]           alu2_out_cmd,
  output logic [PID_W-1:0]           alu2_out_pid,
  output logic [TAG_W-1:0]           alu2_out_tag,
  output logic                       err_nop
);

  logic [NUM_PORTS-1:0] slot_vld;
  logic [CMD_W-1:0]     slot_cmd [NUM_PORTS];
  logic [TAG_W-1:0]     slot_tag [NUM_PORTS];
  logic [NUM_PORTS-1:0] accept, is_nop, elig1, elig2, grant1, grant2, clear;
  logic [PID_W-1:0]     idx1, idx2, ptr1, ptr2;
  logic                 any1, any2, load1, load2;

  assign req_rdy = ~slot_vld;
  assign load1   = ~alu1_out_vld | alu1_out_rdy;
  assign load2   = ~alu2_out_vld | alu2_out_rdy;
  assign clear   = (grant1 & {NUM_PORTS{load1}}) | (grant2 & {NUM_PORTS{load2}});

  // Per-port accept and per-lane eligibility.
  always_comb begin
    lane_e lane;
    accept = '0;
    is_nop = '0;
    elig1  = '0;
    elig2  = '0;
    lane   = LANE_NONE;
    for (int p = 0; p < NUM_PORTS; p++) begin
      accept[p] = req_vld[p] & ~slot_vld[p];
      is_nop[p] = (req_cmd[p*CMD_W +: CMD_W] == CMD_W'(CMD_NOP));
      lane      = cmd_lane(32'(slot_cmd[p]), 32'(ALU2_MIN_CMD));
      elig1[p]  = slot_vld[p] & port_en[p] & (lane == LANE_ADD);
      elig2[p]  = slot_vld[p] & port_en[p] & (lane == LANE_SHIFT);
    end
  end

  calc_prio_sel #(.NUM_PORTS(NUM_PORTS), .PID_W(PID_W)) u_sel1 (
    .elig(elig1), .ptr(ptr1), .grant(grant1), .idx(idx1), .any(any1)
  );

  calc_prio_sel #(.NUM_PORTS(NUM_PORTS), .PID_W(PID_W)) u_sel2 (
    .elig(elig2), .ptr(ptr2), .grant(grant2), .idx(idx2), .any(any2)
  );

`ifdef PRIO_RR_EN
  // Round-robin pointers advance past the granted port only on a real grant.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      ptr1 <= '0;
      ptr2 <= '0;
    end else begin
      if (load1 && any1) ptr1 <= (idx1 == PID_W'(NUM_PORTS-1)) ? '0 : idx1 + PID_W'(1);
      else               ptr1 <= ptr1;
      if (load2 && any2) ptr2 <= (idx2 == PID_W'(NUM_PORTS-1)) ? '0 : idx2 + PID_W'(1);
      else               ptr2 <= ptr2;
    end
  end
`else
  assign ptr1 = '0;
  assign ptr2 = '0;
`endif

  // Slot registers: a NOP is consumed without occupying the slot.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        slot_vld[p] <= 1'b0;
        slot_cmd[p] <= '0;
        slot_tag[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p] && !is_nop[p]) begin
          slot_vld[p] <= 1'b1;
          slot_cmd[p] <= req_cmd[p*CMD_W +: CMD_W];
          slot_tag[p] <= req_tag[p*TAG_W +: TAG_W];
        end else if (clear[p]) begin
          slot_vld[p] <= 1'b0;
        end else begin
          slot_vld[p] <= slot_vld[p];
        end
      end
    end
  end

  // Lane 1 output register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      alu1_out_vld <= 1'b0;
      alu1_out_cmd <= '0;
      alu1_out_pid <= '0;
      alu1_out_tag <= '0;
    end else if (load1 && any1) begin
      alu1_out_vld <= 1'b1;
      alu1_out_cmd <= slot_cmd[idx1];
      alu1_out_pid <= idx1;
      alu1_out_tag <= slot_tag[idx1];
    end else if (load1) begin
      alu1_out_vld <= 1'b0;
    end else begin
      alu1_out_vld <= alu1_out_vld;
    end
  end

  // Lane 2 output register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      alu2_out_vld <= 1'b0;
      alu2_out_cmd <= '0;
      alu2_out_pid <= '0;
      alu2_out_tag <= '0;
    end else if (load2 && any2) begin
      alu2_out_vld <= 1'b1;
      alu2_out_cmd <= slot_cmd[idx2];
      alu2_out_pid <= idx2;
      alu2_out_tag <= slot_tag[idx2];
    end else if (load2) begin
      alu2_out_vld <= 1'b0;
    end else begin
      alu2_out_vld <= alu2_out_vld;
    end
  end

  // Single-cycle NOP error pulse.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      err_nop <= 1'b0;
    end else begin
      err_nop <= |(accept & is_nop);
    end
  end

endmodule

// File: tb/tb_calc_prio_arb.sv
// Directed self-checking bench for calc_prio_arb (default parameters).
module tb_calc_prio_arb;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_vld = 4'h0;
  logic [15:0] req_cmd = 16'h0;
  logic [7:0]  req_tag = 8'h0;
  logic [3:0]  req_rdy;
  logic [3:0]  port_en = 4'hF;
  logic        alu1_out_vld, alu1_out_rdy = 1'b1;
  logic [3:0]  alu1_out_cmd;
  logic [1:0]  alu1_out_pid, alu1_out_tag;
  logic        alu2_out_vld, alu2_out_rdy = 1'b1;
  logic [3:0]  alu2_out_cmd;
  logic [1:0]  alu2_out_pid, alu2_out_tag;
  logic        err_nop;

  int nvec = 0;
  int nerr = 0;

  calc_prio_arb dut (
    .c_clk(c_clk), .reset(reset),
    .req_vld(req_vld), .req_cmd(req_cmd), .req_tag(req_tag), .req_rdy(req_rdy),
    .port_en(port_en),
    .alu1_out_vld(alu1_out_vld), .alu1_out_rdy(alu1_out_rdy), .alu1_out_cmd(alu1_out_cmd),
    .alu1_out_pid(alu1_out_pid), .alu1_out_tag(alu1_out_tag),
    .alu2_out_vld(alu2_out_vld), .alu2_out_rdy(alu2_out_rdy), .alu2_out_cmd(alu2_out_cmd),
    .alu2_out_pid(alu2_out_pid), .alu2_out_tag(alu2_out_tag),
    .err_nop(err_nop)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic [3:0] cmd, input logic [1:0] tag);
    req_vld[p] = 1'b1;
    req_cmd[p*4 +: 4] = cmd;
    req_tag[p*2 +: 2] = tag;
  endtask

  task automatic apply_reset();
    req_vld = 4'h0; req_cmd = 16'h0; req_tag = 8'h0; port_en = 4'hF;
    alu1_out_rdy = 1'b1; alu2_out_rdy = 1'b1;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    nvec++; if (req_rdy !== 4'hF) begin nerr++; $display("FAIL reset_rdy got %h exp F", req_rdy); end
    nvec++; if ({alu1_out_vld, alu2_out_vld, err_nop} !== 3'b000) begin nerr++; $display("FAIL reset_vld got %b exp 000", {alu1_out_vld, alu2_out_vld, err_nop}); end
    nvec++; if ({alu1_out_cmd, alu1_out_pid, alu1_out_tag, alu2_out_cmd, alu2_out_pid, alu2_out_tag} !== 16'h0) begin nerr++; $display("FAIL reset_data got nonzero lane fields"); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    set_req(2, 4'd1, 2'd3);
    tick();
    req_vld = 4'h0;
    nvec++; if (req_rdy !== 4'b1011 || alu1_out_vld !== 1'b0) begin nerr++; $display("FAIL single_accept got rdy=%b vld=%b exp rdy=1011 vld=0", req_rdy, alu1_out_vld); end
    tick();
    nvec++; if ({alu1_out_vld, alu1_out_cmd, alu1_out_pid, alu1_out_tag} !== {1'b1, 4'd1, 2'd2, 2'd3}) begin nerr++; $display("FAIL single_out got vld=%b cmd=%0d pid=%0d tag=%0d exp 1/1/2/3", alu1_out_vld, alu1_out_cmd, alu1_out_pid, alu1_out_tag); end
    nvec++; if (req_rdy !== 4'hF || alu2_out_vld !== 1'b0) begin nerr++; $display("FAIL single_rdy got rdy=%h vld2=%b exp F/0", req_rdy, alu2_out_vld); end
    tick();
    nvec++; if (alu1_out_vld !== 1'b0) begin nerr++; $display("FAIL single_drain got %b exp 0", alu1_out_vld); end
  endtask

  task automatic test_split();
    apply_reset();
    set_req(0, 4'd2, 2'd1);
    set_req(1, 4'd5, 2'd2);
    tick();
    req_vld = 4'h0;
    tick();
    nvec++; if ({alu1_out_vld, alu1_out_cmd, alu1_out_pid, alu1_out_tag} !== {1'b1, 4'd2, 2'd0, 2'd1}) begin nerr++; $display("FAIL split_lane1 got vld=%b cmd=%0d pid=%0d exp 1/2/0", alu1_out_vld, alu1_out_cmd, alu1_out_pid); end
    nvec++; if ({alu2_out_vld, alu2_out_cmd, alu2_out_pid, alu2_out_tag} !== {1'b1, 4'd5, 2'd1, 2'd2}) begin nerr++; $display("FAIL split_lane2 got vld=%b cmd=%0d pid=%0d exp 1/5/1", alu2_out_vld, alu2_out_cmd, alu2_out_pid); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [1:0] exp_pid;
    apply_reset();
    alu2_out_rdy = 1'b0;
    for (int p = 0; p < 4; p++) set_req(p, 4'd6, 2'(p));
    tick();
    req_vld = 4'h0;
    tick();
    for (int c = 0; c < 5; c++) begin
      nvec++; if ({alu2_out_vld, alu2_out_pid, alu2_out_cmd} !== {1'b1, 2'd0, 4'd6} || req_rdy !== 4'b0001) begin nerr++; $display("FAIL bp_hold cyc %0d got vld=%b pid=%0d rdy=%b exp 1/0/0001", c, alu2_out_vld, alu2_out_pid, req_rdy); end
      tick();
    end
    alu2_out_rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      exp_pid = 2'(k);
      nvec++; if ({alu2_out_vld, alu2_out_pid, alu2_out_tag} !== {1'b1, exp_pid, exp_pid}) begin nerr++; $display("FAIL bp_order got vld=%b pid=%0d tag=%0d exp 1/%0d/%0d", alu2_out_vld, alu2_out_pid, alu2_out_tag, exp_pid, exp_pid); end
    end
    tick();
    nvec++; if (alu2_out_vld !== 1'b0 || req_rdy !== 4'hF) begin nerr++; $display("FAIL bp_drain got vld=%b rdy=%h exp 0/F", alu2_out_vld, req_rdy); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [4];
`ifdef PRIO_RR_EN
    exp_seq = '{2'd0, 2'd3, 2'd0, 2'd3};
`else
    exp_seq = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    apply_reset();
    alu1_out_rdy = 1'b0;
    set_req(0, 4'd1, 2'd0);
    set_req(3, 4'd1, 2'd3);
    tick();
    tick();
    nvec++; if ({alu1_out_vld, alu1_out_pid} !== {1'b1, exp_seq[0]}) begin nerr++; $display("FAIL fair_0 got vld=%b pid=%0d exp 1/%0d", alu1_out_vld, alu1_out_pid, exp_seq[0]); end
    for (int k = 1; k < 4; k++) begin
      alu1_out_rdy = 1'b0;
      tick();
      alu1_out_rdy = 1'b1;
      tick();
      nvec++; if ({alu1_out_vld, alu1_out_pid} !== {1'b1, exp_seq[k]}) begin nerr++; $display("FAIL fair_%0d got vld=%b pid=%0d exp 1/%0d", k, alu1_out_vld, alu1_out_pid, exp_seq[k]); end
    end
    req_vld = 4'h0;
    alu1_out_rdy = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_edge_cases();
    apply_reset();
    set_req(1, 4'd0, 2'd2);
    tick();
    req_vld = 4'h0;
    nvec++; if ({err_nop, req_rdy, alu1_out_vld, alu2_out_vld} !== {1'b1, 4'hF, 2'b00}) begin nerr++; $display("FAIL nop_pulse got err=%b rdy=%h v1=%b v2=%b exp 1/F/0/0", err_nop, req_rdy, alu1_out_vld, alu2_out_vld); end
    tick();
    nvec++; if ({err_nop, alu1_out_vld, alu2_out_vld} !== 3'b000) begin nerr++; $display("FAIL nop_end got %b exp 000", {err_nop, alu1_out_vld, alu2_out_vld}); end
    port_en = 4'b0111;
    set_req(3, 4'd2, 2'd1);
    tick();
    req_vld = 4'h0;
    tick(); tick();
    nvec++; if (alu1_out_vld !== 1'b0 || req_rdy !== 4'b0111) begin nerr++; $display("FAIL en_hold got vld=%b rdy=%b exp 0/0111", alu1_out_vld, req_rdy); end
    port_en = 4'hF;
    tick();
    nvec++; if ({alu1_out_vld, alu1_out_cmd, alu1_out_pid, alu1_out_tag} !== {1'b1, 4'd2, 2'd3, 2'd1}) begin nerr++; $display("FAIL en_grant got vld=%b cmd=%0d pid=%0d exp 1/2/3", alu1_out_vld, alu1_out_cmd, alu1_out_pid); end
    tick();
  endtask

  task automatic test_reset_midop();
    apply_reset();
    alu1_out_rdy = 1'b0;
    alu2_out_rdy = 1'b0;
    set_req(0, 4'd1, 2'd0);
    set_req(1, 4'd5, 2'd1);
    set_req(2, 4'd1, 2'd2);
    set_req(3, 4'd5, 2'd3);
    tick();
    req_vld = 4'h0;
    tick();
    nvec++; if ({alu1_out_vld, alu2_out_vld, req_rdy} !== {2'b11, 4'b0011}) begin nerr++; $display("FAIL mid_pre got v=%b%b rdy=%b exp 11/0011", alu1_out_vld, alu2_out_vld, req_rdy); end
    #2 reset = 1'b0;
    #1;
    nvec++; if ({alu1_out_vld, alu2_out_vld, req_rdy} !== {2'b00, 4'hF}) begin nerr++; $display("FAIL mid_reset got v=%b%b rdy=%h exp 00/F", alu1_out_vld, alu2_out_vld, req_rdy); end
    tick();
    reset = 1'b1;
    alu1_out_rdy = 1'b1;
    alu2_out_rdy = 1'b1;
    set_req(2, 4'd3, 2'd2);
    tick();
    req_vld = 4'h0;
    nvec++; if (alu1_out_vld !== 1'b0) begin nerr++; $display("FAIL mid_lat0 got %b exp 0", alu1_out_vld); end
    tick();
    nvec++; if ({alu1_out_vld, alu1_out_cmd, alu1_out_pid, alu1_out_tag} !== {1'b1, 4'd3, 2'd2, 2'd2}) begin nerr++; $display("FAIL mid_lat1 got vld=%b cmd=%0d pid=%0d exp 1/3/2", alu1_out_vld, alu1_out_cmd, alu1_out_pid); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_split();
    test_backpressure();
    test_fairness();
    test_edge_cases();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
